// File: rtl/window_addr_gen.sv
// Sliding-window BRAM read address generator.
// For each window origin (ox, oy) the generator walks a KSIZE x KSIZE kernel
// over a padded image stored with STRIDE words per row. The kernel column (kx)
// changes fastest, then the kernel row (ky), then ox, then oy. Addresses are
// built up by additions only, so no runtime multiplier is needed.
// Address, tap flags and counters advance only when the consumer accepts an
// address (addr_valid_o && addr_ready_i).
//
// state | meaning
// IDLE  | waiting for start_i; outputs quiet
// RUN   | presenting addresses; advance on each accepted transfer
// DONE  | one-cycle done_o pulse after the final transfer
module window_addr_gen #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int STRIDE = 516,
  parameter int KSIZE  = 5,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              addr_ready_i,
  output logic              addr_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              win_first_o,
  output logic              win_last_o,
  output logic              frame_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int KW = 4;
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [KW-1:0]     K_LAST   = KW'(KSIZE - 1);
  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  // Jump from the last tap of one kernel row to the first tap of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE - KSIZE + 1);

  // Reject geometries whose padded rows are too narrow or whose padded frame
  // does not fit in the address space.
  if ((KSIZE < 1) || (KSIZE > 15) || (STRIDE < IMG_W + KSIZE - 1) ||
      ((longint'(IMG_H + KSIZE - 1) * longint'(STRIDE)) > (longint'(1) << ADDR_W)))
  begin : g_param_check
    $fatal(1, "window_addr_gen: illegal KSIZE/STRIDE/IMG_H/ADDR_W combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     kx_q, kx_d;
  logic [KW-1:0]     ky_q, ky_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Address of tap (0,0) of the current window, and of the current origin row.
  logic [ADDR_W-1:0] win_base_q, win_base_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  logic run, xfer, kx_end, ky_end, ox_end, oy_end;

  assign run    = (state_q == S_RUN);
  assign xfer   = run && addr_ready_i;
  assign kx_end = (kx_q == K_LAST);
  assign ky_end = (ky_q == K_LAST);
  assign ox_end = (ox_q == X_LAST);
  assign oy_end = (oy_q == Y_LAST);

  // Next-state logic: FSM transitions and incremental address stepping.
  always_comb begin
    state_d    = state_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    addr_d     = addr_q;
    win_base_d = win_base_q;
    row_base_d = row_base_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_RUN;
          kx_d       = '0;
          ky_d       = '0;
          ox_d       = '0;
          oy_d       = '0;
          addr_d     = '0;
          win_base_d = '0;
          row_base_d = '0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (!kx_end) begin
            kx_d   = kx_q + 1'b1;
            addr_d = addr_q + ONE_A;
          end else if (!ky_end) begin
            kx_d   = '0;
            ky_d   = ky_q + 1'b1;
            addr_d = addr_q + ROW_STEP;
          end else begin
            kx_d = '0;
            ky_d = '0;
            if (!ox_end) begin
              ox_d       = ox_q + 1'b1;
              win_base_d = win_base_q + ONE_A;
              addr_d     = win_base_q + ONE_A;
            end else if (!oy_end) begin
              ox_d       = '0;
              oy_d       = oy_q + 1'b1;
              row_base_d = row_base_q + STRIDE_A;
              win_base_d = row_base_q + STRIDE_A;
              addr_d     = row_base_q + STRIDE_A;
            end else begin
              // Final tap of the frame accepted: park everything at zero.
              ox_d       = '0;
              oy_d       = '0;
              addr_d     = '0;
              win_base_d = '0;
              row_base_d = '0;
              state_d    = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      kx_q       <= '0;
      ky_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      addr_q     <= '0;
      win_base_q <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      addr_q     <= addr_d;
      win_base_q <= win_base_d;
      row_base_q <= row_base_d;
    end
  end

  // Outputs are decoded from registered state only, so they hold during stalls.
  assign addr_valid_o = run;
  assign busy_o       = run;
  assign done_o       = (state_q == S_DONE);
  assign addr_o       = addr_q;
  assign win_first_o  = run && (kx_q == '0) && (ky_q == '0);
  assign win_last_o   = run && kx_end && ky_end;
  assign frame_last_o = run && kx_end && ky_end && ox_end && oy_end;

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: a 4x3 image with a 3x3 kernel and a
// 4x2 raster (KSIZE=1) instance, both on stride 6.
module tb_window_addr_gen;

  localparam int W = 4, H = 3, S = 6, K = 3, AW = 8;
  localparam int TOTAL = W * H * K * K;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, addr_ready;
  logic          addr_valid, win_first, win_last, frame_last, busy, done;
  logic [AW-1:0] addr;

  logic          k1_start, k1_ready;
  logic          k1_valid, k1_first, k1_last, k1_flast, k1_busy, k1_done;
  logic [AW-1:0] k1_addr;

  int total = 0;
  int bad   = 0;

  int hand_first [18] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 1, 2, 3, 7, 8, 9, 13, 14, 15};
  int hand_last  [9]  = '{15, 16, 17, 21, 22, 23, 27, 28, 29};
  int hand_k1    [8]  = '{0, 1, 2, 3, 6, 7, 8, 9};

  always #5 clk = ~clk;

  window_addr_gen #(.IMG_W(W), .IMG_H(H), .STRIDE(S), .KSIZE(K), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .addr_ready_i(addr_ready),
    .addr_valid_o(addr_valid), .addr_o(addr), .win_first_o(win_first),
    .win_last_o(win_last), .frame_last_o(frame_last), .busy_o(busy), .done_o(done)
  );

  window_addr_gen #(.IMG_W(4), .IMG_H(2), .STRIDE(6), .KSIZE(1), .ADDR_W(AW)) dut_k1 (
    .clk_i(clk), .rst_i(rst), .start_i(k1_start), .addr_ready_i(k1_ready),
    .addr_valid_o(k1_valid), .addr_o(k1_addr), .win_first_o(k1_first),
    .win_last_o(k1_last), .frame_last_o(k1_flast), .busy_o(k1_busy), .done_o(k1_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference address for transfer n: kx fastest, then ky, ox, oy.
  function automatic int exp_addr(input int n);
    int kx, ky, ox, oy;
    kx = n % K;
    ky = (n / K) % K;
    ox = (n / (K * K)) % W;
    oy = n / (K * K * W);
    return (oy + ky) * S + ox + kx;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 32'(addr_valid), 0);
    chk({tag, "_addr"},  32'(addr), 0);
    chk({tag, "_first"}, 32'(win_first), 0);
    chk({tag, "_last"},  32'(win_last), 0);
    chk({tag, "_flast"}, 32'(frame_last), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // Runs one frame; rst_at/start_at are transfer indices (-1 = never).
  task automatic run_frame(input bit rand_ready, input int rst_at, input int start_at,
                           input bit use_hand);
    int  n = 0;
    int  cyc = 0;
    bit  v;
    bit  fired = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
    while (n < TOTAL && cyc < 2000) begin
      chk("valid", 32'(addr_valid), 1);
      chk("addr", 32'(addr), 32'(exp_addr(n)));
      chk("win_first", 32'(win_first), 32'(n % (K * K) == 0));
      chk("win_last", 32'(win_last), 32'(n % (K * K) == K * K - 1));
      chk("frame_last", 32'(frame_last), 32'(n == TOTAL - 1));
      if (use_hand && n < 18) chk("hand_first", 32'(addr), 32'(hand_first[n]));
      if (use_hand && n >= TOTAL - 9) chk("hand_last", 32'(addr), 32'(hand_last[n - (TOTAL - 9)]));
      if (n == rst_at) begin
        rst = 1'b1;
        addr_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        addr_ready = 1'b0;
        check_quiet("abort");
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done), 0);
        return;
      end
      start = (n == start_at && !fired);
      if (start) fired = 1'b1;
      addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      v = addr_valid;
      @(posedge clk); #1;
      if (v && addr_ready) n++;
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
    chk("xfer_count", 32'(n), 32'(TOTAL));
    chk("done_pulse", 32'(done), 1);
    chk("valid_after", 32'(addr_valid), 0);
    chk("busy_after", 32'(busy), 0);
    @(posedge clk); #1;
    chk("done_single", 32'(done), 0);
    chk("idle_valid", 32'(addr_valid), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; addr_ready = 1'b0;
    k1_start = 1'b0; k1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    check_quiet("reset");
    @(posedge clk); #1;
    chk("start_with_rst_ignored", 32'(addr_valid), 0);

    run_frame(1'b0, -1, -1, 1'b1);
    run_frame(1'b1, -1, -1, 1'b0);
    run_frame(1'b1, 50, -1, 1'b0);
    run_frame(1'b0, -1, -1, 1'b1);
    run_frame(1'b1, -1, 20, 1'b0);

    k1_start = 1'b1;
    @(posedge clk); #1;
    k1_start = 1'b0;
    k1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("k1_valid", 32'(k1_valid), 1);
      chk("k1_busy", 32'(k1_busy), 1);
      chk("k1_addr", 32'(k1_addr), 32'(hand_k1[i]));
      chk("k1_first", 32'(k1_first), 1);
      chk("k1_last", 32'(k1_last), 1);
      chk("k1_flast", 32'(k1_flast), 32'(i == 7));
      @(posedge clk); #1;
    end
    k1_ready = 1'b0;
    chk("k1_done", 32'(k1_done), 1);
    chk("k1_valid_after", 32'(k1_valid), 0);
    @(posedge clk); #1;
    chk("k1_done_single", 32'(k1_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 512: output image width in pixels (window origins per row).
REQ-002 SHALL have parameter IMG_H, default 512: output image height in pixels (window origin rows).
REQ-003 SHALL have parameter STRIDE, default 516: BRAM words per padded stored row.
REQ-004 SHALL have parameter KSIZE, default 5: square kernel edge, 1..15.
REQ-005 SHALL have parameter ADDR_W, default 19: address width.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle frame start request.
REQ-009 addr_ready  input  1  consumer accepts addr this cycle.
REQ-010 addr_valid  output  1  addr holds a valid BRAM read address.
REQ-011 addr  output  ADDR_W  BRAM read address.
REQ-012 win_first  output  1  addr is first tap (kx=0, ky=0) of a window.
REQ-013 win_last  output  1  addr is last tap (kx=KSIZE-1, ky=KSIZE-1) of a window.
REQ-014 frame_last  output  1  addr is last tap of last window of frame.
REQ-015 busy  output  1  high in RUN state.
REQ-016 done  output  1  one-cycle pulse after final transfer.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE on handshake of frame_last; DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL emit, per window origin (ox, oy), addresses (oy+ky)*STRIDE + (ox+kx); order: kx fastest, then ky, then ox, then oy; all counters start at 0.
REQ-019 SHALL emit exactly IMG_W*IMG_H*KSIZE*KSIZE addresses per frame (default 6,553,600).
REQ-020 SHALL compute addresses incrementally (add 1, add STRIDE-KSIZE+1, row-base add STRIDE); no runtime multiplier.
REQ-021 SHALL assert addr_valid with first address 0 in the cycle after start is sampled in IDLE (latency 1).
REQ-022 SHALL treat transfer as addr_valid && addr_ready; advance counters only on transfer.
REQ-023 SHALL hold addr, win_first, win_last, frame_last stable while addr_valid && !addr_ready.
REQ-024 SHALL sustain one address per cycle when addr_ready is held high (no bubbles within or between windows).
REQ-025 SHALL deassert addr_valid in the cycle after the frame_last transfer; done=1 in that same cycle (DONE state).
REQ-026 SHALL ignore start while in RUN or DONE; start in same cycle as rst SHALL be ignored.
REQ-027 SHALL, with KSIZE=1, degenerate to raster scan oy*STRIDE+ox with win_first=win_last=1 on every address.
REQ-028 SHALL flag at elaboration (fatal) if STRIDE < IMG_W+KSIZE-1 or (IMG_H+KSIZE-1)*STRIDE > 2**ADDR_W.
REQ-029 frame_last SHALL imply win_last; win_first and win_last SHALL both be 1 only when KSIZE=1.

Reset
REQ-030 SHALL, on rst sampled high, force IDLE and set addr_valid=0, addr=0, win_first=0, win_last=0, frame_last=0, busy=0, done=0, all counters 0.
REQ-031 SHALL abort any frame on mid-operation rst with no done pulse; next frame SHALL restart at address 0.

Verification
REQ-032 IMG_W=4, IMG_H=3, STRIDE=6, KSIZE=3, addr_ready=1, start pulse -> addresses 0,1,2,6,7,8,12,13,14 (win_first on 0, win_last on 14), next window 1,2,3,7,8,9,13,14,15.
REQ-033 Same params, full frame -> 108 transfers, last window 15,16,17,21,22,23,27,28,29, frame_last on 29, done pulse next cycle, busy low after.
REQ-034 Same params, addr_ready random 50% -> identical address sequence, outputs stable during stalls, no loss/duplication.
REQ-035 rst asserted at transfer 50 -> all outputs 0 next cycle, no done; subsequent start -> first addr 0.
REQ-036 start pulsed while busy at transfer 20 -> sequence unaffected, still 108 transfers, single done.
REQ-037 KSIZE=1, IMG_W=4, IMG_H=2, STRIDE=6 -> addresses 0,1,2,3,6,7,8,9, win_first=win_last=1 on each, frame_last on 9.
